// File: rtl/noc_splitter_1to2.sv
// 1-to-2 packet splitter: one 4-phase input channel, two 4-phase output channels with one buffer each.
// Optional macro NOC_SPLITTER_SYNC_EN adds 2-flop synchronizers on in_req, out1_ack and out2_ack.
module noc_splitter_1to2 #(
  parameter int unsigned WIDTH_packet = 57,
  parameter int unsigned ROUTE_BIT    = 56
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_req,
  output logic                    in_ack,
  input  logic [WIDTH_packet-1:0] in_data,
  output logic                    out1_req,
  input  logic                    out1_ack,
  output logic [WIDTH_packet-1:0] out1_data,
  output logic                    out2_req,
  input  logic                    out2_ack,
  output logic [WIDTH_packet-1:0] out2_data
);

  typedef enum logic {StInIdle, StInWaitLow} in_st_e;
  typedef enum logic [1:0] {StOutIdle, StOutReq, StOutWaitLow} out_st_e;

  logic in_req_s, out1_ack_s, out2_ack_s;

`ifdef NOC_SPLITTER_SYNC_EN
  logic [1:0] in_req_sync_q, out1_ack_sync_q, out2_ack_sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_req_sync_q   <= '0;
      out1_ack_sync_q <= '0;
      out2_ack_sync_q <= '0;
    end else begin
      in_req_sync_q   <= {in_req_sync_q[0], in_req};
      out1_ack_sync_q <= {out1_ack_sync_q[0], out1_ack};
      out2_ack_sync_q <= {out2_ack_sync_q[0], out2_ack};
    end
  end

  assign in_req_s   = in_req_sync_q[1];
  assign out1_ack_s = out1_ack_sync_q[1];
  assign out2_ack_s = out2_ack_sync_q[1];
`else
  assign in_req_s   = in_req;
  assign out1_ack_s = out1_ack;
  assign out2_ack_s = out2_ack;
`endif

  in_st_e                  in_st_q, in_st_d;
  out_st_e                 o1_st_q, o1_st_d, o2_st_q, o2_st_d;
  logic                    in_ack_q, in_ack_d;
  logic                    out1_req_q, out1_req_d, out2_req_q, out2_req_d;
  logic                    full1_q, full1_d, full2_q, full2_d;
  logic [WIDTH_packet-1:0] buf1_q, buf1_d, buf2_q, buf2_d;
  logic                    route;

  assign route = in_data[ROUTE_BIT];

  always_comb begin
    in_st_d    = in_st_q;
    o1_st_d    = o1_st_q;
    o2_st_d    = o2_st_q;
    in_ack_d   = in_ack_q;
    out1_req_d = out1_req_q;
    out2_req_d = out2_req_q;
    full1_d    = full1_q;
    full2_d    = full2_q;
    buf1_d     = buf1_q;
    buf2_d     = buf2_q;

    // Acceptance looks only at registered full flags; a clear on this edge is seen next edge.
    unique case (in_st_q)
      StInIdle: begin
        if (in_req_s && !route && !full1_q) begin
          buf1_d   = in_data;
          full1_d  = 1'b1;
          in_ack_d = 1'b1;
          in_st_d  = StInWaitLow;
        end else if (in_req_s && route && !full2_q) begin
          buf2_d   = in_data;
          full2_d  = 1'b1;
          in_ack_d = 1'b1;
          in_st_d  = StInWaitLow;
        end
      end
      StInWaitLow: begin
        if (!in_req_s) begin
          in_ack_d = 1'b0;
          in_st_d  = StInIdle;
        end
      end
      default: in_st_d = StInIdle;
    endcase

    unique case (o1_st_q)
      StOutIdle: begin
        if (full1_q) begin
          out1_req_d = 1'b1;
          o1_st_d    = StOutReq;
        end
      end
      StOutReq: begin
        if (out1_ack_s) begin
          out1_req_d = 1'b0;
          full1_d    = 1'b0;
          o1_st_d    = StOutWaitLow;
        end
      end
      StOutWaitLow: if (!out1_ack_s) o1_st_d = StOutIdle;
      default:      o1_st_d = StOutIdle;
    endcase

    unique case (o2_st_q)
      StOutIdle: begin
        if (full2_q) begin
          out2_req_d = 1'b1;
          o2_st_d    = StOutReq;
        end
      end
      StOutReq: begin
        if (out2_ack_s) begin
          out2_req_d = 1'b0;
          full2_d    = 1'b0;
          o2_st_d    = StOutWaitLow;
        end
      end
      StOutWaitLow: if (!out2_ack_s) o2_st_d = StOutIdle;
      default:      o2_st_d = StOutIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_st_q    <= StInIdle;
      o1_st_q    <= StOutIdle;
      o2_st_q    <= StOutIdle;
      in_ack_q   <= 1'b0;
      out1_req_q <= 1'b0;
      out2_req_q <= 1'b0;
      full1_q    <= 1'b0;
      full2_q    <= 1'b0;
      buf1_q     <= '0;
      buf2_q     <= '0;
    end else begin
      in_st_q    <= in_st_d;
      o1_st_q    <= o1_st_d;
      o2_st_q    <= o2_st_d;
      in_ack_q   <= in_ack_d;
      out1_req_q <= out1_req_d;
      out2_req_q <= out2_req_d;
      full1_q    <= full1_d;
      full2_q    <= full2_d;
      buf1_q     <= buf1_d;
      buf2_q     <= buf2_d;
    end
  end

  assign in_ack    = in_ack_q;
  assign out1_req  = out1_req_q;
  assign out2_req  = out2_req_q;
  assign out1_data = buf1_q;
  assign out2_data = buf2_q;

endmodule

// File: tb/tb_noc_splitter_1to2.sv
// Directed plus random-stream bench for noc_splitter_1to2; latency checks follow NOC_SPLITTER_SYNC_EN.
module tb_noc_splitter_1to2;

  localparam int unsigned W = 57;
`ifdef NOC_SPLITTER_SYNC_EN
  localparam int S = 2;
`else
  localparam int S = 0;
`endif
  localparam logic [W-1:0] P6 = (57'd1 << 56) | 57'd6;
  localparam logic [W-1:0] P9 = (57'd1 << 56) | 57'd9;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_req, in_ack;
  logic [W-1:0] in_data;
  logic         out1_req, out1_ack, out2_req, out2_ack;
  logic [W-1:0] out1_data, out2_data;

  int n_tests = 0;
  int n_fail  = 0;
  bit out2_seen;

  always #5 clk = ~clk;

  noc_splitter_1to2 #(.WIDTH_packet(57), .ROUTE_BIT(56)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_req   (in_req),
    .in_ack   (in_ack),
    .in_data  (in_data),
    .out1_req (out1_req),
    .out1_ack (out1_ack),
    .out1_data(out1_data),
    .out2_req (out2_req),
    .out2_ack (out2_ack),
    .out2_data(out2_data)
  );

  task automatic tick;
    @(posedge clk);
    #1;
    if (out2_req) out2_seen = 1'b1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [W-1:0] pkt);
    in_data = pkt;
    in_req  = 1'b1;
    for (int i = 0; i < 500 && !in_ack; i++) tick;
    check("send_ack_high", 64'(in_ack), 64'd1);
    in_req = 1'b0;
    for (int i = 0; i < 500 && in_ack; i++) tick;
    check("send_ack_low", 64'(in_ack), 64'd0);
  endtask

  task automatic recv(input int k, input logic [W-1:0] exp, input int dly);
    for (int i = 0; i < 500 && !((k == 1) ? out1_req : out2_req); i++) tick;
    check((k == 1) ? "recv1_req" : "recv2_req", 64'((k == 1) ? out1_req : out2_req), 64'd1);
    check((k == 1) ? "recv1_data" : "recv2_data", 64'((k == 1) ? out1_data : out2_data), 64'(exp));
    repeat (dly) tick;
    if (k == 1) out1_ack = 1'b1;
    else        out2_ack = 1'b1;
    for (int i = 0; i < 500 && ((k == 1) ? out1_req : out2_req); i++) tick;
    check((k == 1) ? "recv1_req_drop" : "recv2_req_drop",
          64'((k == 1) ? out1_req : out2_req), 64'd0);
    if (k == 1) out1_ack = 1'b0;
    else        out2_ack = 1'b0;
  endtask

  logic [W-1:0] pkts[200];
  logic [W-1:0] q1[$];
  logic [W-1:0] q2[$];
  int n1, n2;

  initial begin
    // Reset held with a pending request.
    reset = 1'b1; in_req = 1'b1; in_data = 57'd5; out1_ack = 1'b0; out2_ack = 1'b0;
    repeat (2) tick;
    check("rst_in_ack", 64'(in_ack), 64'd0);
    check("rst_out1_req", 64'(out1_req), 64'd0);
    check("rst_out2_req", 64'(out2_req), 64'd0);
    check("rst_out1_data", 64'(out1_data), 64'd0);
    check("rst_out2_data", 64'(out2_data), 64'd0);
    reset = 1'b0;
    repeat (S) tick;
    check("rel_ack_not_yet", 64'(in_ack), 64'd0);
    tick;
    check("rel_ack_lat", 64'(in_ack), 64'd1);
    in_req = 1'b0;
    recv(1, 57'd5, 0);
    for (int i = 0; i < 50 && in_ack; i++) tick;
    check("rel_ack_low", 64'(in_ack), 64'd0);
    repeat (4) tick;

    // Single packet to out1, exact latency.
    out2_seen = 1'b0;
    in_data = 57'd5; in_req = 1'b1;
    repeat (S) tick;
    tick;
    check("t2_ack_lat", 64'(in_ack), 64'd1);
    check("t2_req_early", 64'(out1_req), 64'd0);
    tick;
    check("t2_req_lat", 64'(out1_req), 64'd1);
    check("t2_data", 64'(out1_data), 64'd5);
    in_req = 1'b0;
    tick;
    recv(1, 57'd5, 0);
    for (int i = 0; i < 50 && in_ack; i++) tick;
    check("t2_ack_low", 64'(in_ack), 64'd0);
    repeat (4) tick;
    check("t2_out2_quiet", 64'(out2_seen), 64'd0);

    // Stalled out1 does not block out2.
    send(57'd5);
    send(P6);
    for (int i = 0; i < 50 && !out2_req; i++) tick;
    check("t3_out2_req", 64'(out2_req), 64'd1);
    check("t3_out2_data", 64'(out2_data), 64'(P6));
    check("t3_out1_pending", 64'(out1_req), 64'd1);
    check("t3_out1_data", 64'(out1_data), 64'd5);
    recv(2, P6, 1);
    recv(1, 57'd5, 0);
    repeat (4) tick;

    // Second packet to a full out1 stalls until the first drains.
    send(57'd5);
    for (int i = 0; i < 50 && !out1_req; i++) tick;
    in_data = 57'd7; in_req = 1'b1;
    repeat (10) tick;
    check("t4_stall", 64'(in_ack), 64'd0);
    check("t4_hold_data", 64'(out1_data), 64'd5);
    recv(1, 57'd5, 0);
    for (int i = 0; i < 50 && !in_ack; i++) tick;
    check("t4_accept", 64'(in_ack), 64'd1);
    in_req = 1'b0;
    for (int i = 0; i < 50 && in_ack; i++) tick;
    recv(1, 57'd7, 2);
    repeat (4) tick;

    // Asynchronous reset mid-handshake on out2.
    send(P9);
    for (int i = 0; i < 50 && !out2_req; i++) tick;
    check("t5_out2_req", 64'(out2_req), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("t5_async_req", 64'(out2_req), 64'd0);
    check("t5_async_data", 64'(out2_data), 64'd0);
    check("t5_async_ack", 64'(in_ack), 64'd0);
    tick;
    reset = 1'b0;
    repeat (6) tick;
    check("t5_post_out2", 64'(out2_req), 64'd0);
    check("t5_post_out1", 64'(out1_req), 64'd0);

    // Random stream with per-output scoreboards.
    n1 = 0; n2 = 0;
    for (int i = 0; i < 200; i++) begin
      pkts[i] = W'({$urandom, $urandom});
      if (pkts[i][56]) begin q2.push_back(pkts[i]); n2++; end
      else             begin q1.push_back(pkts[i]); n1++; end
    end
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          send(pkts[i]);
          repeat ($urandom_range(0, 2)) tick;
        end
      end
      begin
        for (int i = 0; i < n1; i++) recv(1, q1.pop_front(), int'($urandom_range(0, 5)));
      end
      begin
        for (int i = 0; i < n2; i++) recv(2, q2.pop_front(), int'($urandom_range(0, 5)));
      end
    join
    repeat (20) tick;
    check("rnd_no_extra1", 64'(out1_req), 64'd0);
    check("rnd_no_extra2", 64'(out2_req), 64'd0);
    check("rnd_in_idle", 64'(in_ack), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/noc_splitter_1to2.md
Name: noc_splitter_1to2

Overview:
- Clocked 1-to-2 packet splitter: the dispatch-side counterpart of the 2-to-1 merge arbiter in the NoC.
- Accepts 57-bit packets on one 4-phase req/ack input channel.
- Routes each packet on a single route bit to one of two 4-phase output channels.
- Holds one packet per output, so a stalled output does not block traffic headed to the other output.

Parameters:
- WIDTH_packet, 57, packet width in bits.
- ROUTE_BIT, 56, packet bit index that selects the output: 0 routes to out1, 1 routes to out2.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_req  input  1  input-channel request; in_data is stable while it is high.
- in_ack  output  1  input-channel acknowledge.
- in_data  input  WIDTH_packet  input packet.
- out1_req  output  1  output-1 request.
- out1_ack  input  1  output-1 acknowledge.
- out1_data  output  WIDTH_packet  output-1 packet.
- out2_req  output  1  output-2 request.
- out2_ack  input  1  output-2 acknowledge.
- out2_data  output  WIDTH_packet  output-2 packet.

Behaviour:
- Reset (asynchronous, active-high), applied immediately:
  - in_ack, out1_req, out2_req = 0; out1_data, out2_data = 0.
  - Both buffers empty (full1 = full2 = 0); all FSMs idle.
- Reset mid-handshake: any buffered packet is discarded and no ack or req is left high.
- Protocol on every channel is 4-phase: req rises with data stable -> ack rises -> req falls -> ack falls.
- Input FSM {IN_IDLE, IN_WAIT_LOW}, target t = in_data[ROUTE_BIT]:
  - IN_IDLE, in_req=1, full_t=0: latch in_data into buf_t, set full_t, in_ack<=1, go to IN_WAIT_LOW.
  - IN_IDLE, in_req=1, full_t=1: stall; in_ack stays 0 and nothing is latched. in_data must stay stable.
  - IN_WAIT_LOW, in_req=0: in_ack<=0, go to IN_IDLE.
- Output FSM k ∈ {1,2}, states {O_IDLE, O_REQ, O_WAIT_LOW}:
  - O_IDLE, full_k=1: outk_req<=1, go to O_REQ. outk_data = buf_k and is stable while outk_req=1.
  - O_REQ, outk_ack=1: outk_req<=0, clear full_k, go to O_WAIT_LOW.
  - O_WAIT_LOW, outk_ack=0: go to O_IDLE.
- Latency with no stall, input sampled high at edge E:
  - in_ack=1 and full_t=1 after E.
  - outt_req=1 after E+1.
- Full/clear race: input acceptance uses the registered full_t. A packet for output k arriving on the same edge that full_k clears is accepted on the next edge, so there is no same-cycle overwrite.
- The two output FSMs are independent; out1 and out2 may be in flight simultaneously.
- Ordering: FIFO order is guaranteed per output only; relative order between outputs is not guaranteed.
- outk_data holds the last value after the handshake until overwritten by the next buffered packet.
- No packet is ever dropped or duplicated except on reset.

Optional Feature:
- Macro: NOC_SPLITTER_SYNC_EN.
- Defined:
  - in_req, out1_ack and out2_ack each pass through a 2-flop synchronizer (reset to 0) before the FSMs see them.
  - Every handshake response gains 2 cycles: in_ack rises after E+2 and outt_req after E+3.
  - in_data is still sampled directly; it is stable by protocol.
- Not defined: raw inputs feed the FSMs, with the timing given above.

Test Plan:
- Reset with in_req=1 held -> in_ack, out1_req, out2_req all 0. Release reset -> in_ack=1 one edge later.
- Send packet 0x000_0000_0000_0005 (bit56=0), out1_ack responding 1 cycle after req ->
  - in_ack high 1 cycle after in_req is sampled;
  - out1_req high the next cycle with out1_data=5;
  - out2_req never rises.
- Send 5 then (1<<56)|6 while out1_ack is held low ->
  - second packet accepted;
  - out2_req rises with out2_data=(1<<56)|6;
  - out1 remains pending with data 5.
- Send 5 and then 7, both to out1, with out1_ack held low ->
  - in_ack for 7 stays 0 until out1 completes 5;
  - then 7 is accepted;
  - out1 delivers 5 then 7 in order.
- Assert reset while out2_req=1 and out2_ack=0 -> out2_req drops immediately; after release, out2_req stays 0.
- Random 200-packet stream with random ack delays of 0–5 cycles ->
  - every sent packet appears exactly once on the output selected by bit56, in per-output order;
  - repeat the run with NOC_SPLITTER_SYNC_EN defined and check the +2-cycle latency.
